// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM encoding
// and the signed-overflow helper.
package alu_exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // b_eff is the second operand's sign as seen by the adder (inverted for sub)
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b_eff,
                                        input logic sign_res);
        return (sign_a == sign_b_eff) && (sign_res != sign_a);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks
// per operation, low WIDTH bits of the product only.
module alu_mul_seq
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] acc_nxt_s;

    // Accumulate the current partial product; also the final product on the last step
    always_comb begin
        acc_nxt_s = acc_r;
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    assign product = acc_nxt_s;
    assign done    = (count_r == {CW{1'b0}});

    // Operand shift registers, accumulator and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= CW'(WIDTH - 1);
        end else if (run) begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (!done) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            count_r  <= count_r;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle add/sub/and/or/slt
// and a multi-cycle multiply that stalls issue while it runs.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             mul_start_s;
    logic             simple_wr_s;
    logic             mul_wr_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             ovf_add_s;
    logic             ovf_sub_s;
    logic [WIDTH-1:0] simple_res_s;
    logic             simple_ovf_s;

    // Accepting while a result is pending is only allowed if it drains on the same edge
    assign in_ready    = (state_r == IDLE) & (~out_valid | out_ready);
    assign accept_s    = in_valid & in_ready;
    assign mul_start_s = accept_s & (alu_control == ALU_MUL);
    assign simple_wr_s = accept_s & (alu_control != ALU_MUL);
    assign mul_wr_s    = (state_r == BUSY) & mul_done_s;

    assign sum_s     = src_a + src_b;
    assign diff_s    = src_a - src_b;
    assign ovf_add_s = signed_ovf(src_a[WIDTH-1], src_b[WIDTH-1], sum_s[WIDTH-1]);
    assign ovf_sub_s = signed_ovf(src_a[WIDTH-1], ~src_b[WIDTH-1], diff_s[WIDTH-1]);

    // Single-cycle datapath; reserved codes fall through to a zero result
    always_comb begin
        simple_res_s = {WIDTH{1'b0}};
        simple_ovf_s = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                simple_res_s = sum_s;
                simple_ovf_s = ovf_add_s;
            end
            ALU_SUB: begin
                simple_res_s = diff_s;
                simple_ovf_s = ovf_sub_s;
            end
            ALU_AND: simple_res_s = src_a & src_b;
            ALU_OR:  simple_res_s = src_a | src_b;
            ALU_SLT: simple_res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ ovf_sub_s};
            default: begin
                simple_res_s = {WIDTH{1'b0}};
                simple_ovf_s = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mul_start_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (mul_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result register; a fresh write takes priority over a drain on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (simple_wr_s) begin
            out_valid <= 1'b1;
            result    <= simple_res_s;
            zero      <= (simple_res_s == {WIDTH{1'b0}});
            overflow  <= simple_ovf_s;
        end else if (mul_wr_s) begin
            out_valid <= 1'b1;
            result    <= mul_product_s;
            zero      <= (mul_product_s == {WIDTH{1'b0}});
            overflow  <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .run     (state_r == BUSY),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations from a behavioural model are
// queued at issue and compared when the unit hands a result over.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    alu_control = 3'b000;
    logic [W-1:0]  src_a = 32'h0;
    logic [W-1:0]  src_b = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;

    logic [33:0]   sb_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: returns {overflow, zero, result}
    function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [32:0] wide;
        logic [63:0]        p;
        logic [31:0]        r;
        logic               v;
        r = 32'h0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = $signed({a[31], a}) + $signed({b[31], b});
                r = wide[31:0];
                v = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
            end
            ALU_SUB: begin
                wide = $signed({a[31], a}) - $signed({b[31], b});
                r = wide[31:0];
                v = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_MUL: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0];
            end
            default: r = 32'h0;
        endcase
        return {v, (r == 32'h0), r};
    endfunction

    // Output monitor: a transfer happens on the next rising edge
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", {31'h0, out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_result", result, e[31:0]);
                check_val("sb_zero", {31'h0, zero}, {31'h0, e[32]});
                check_val("sb_ovf", {31'h0, overflow}, {31'h0, e[33]});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int budget;
        budget = 0;
        while (!in_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_val("issue_ready", {31'h0, in_ready}, 32'd1);
        alu_control = op;
        src_a = a;
        src_b = b;
        in_valid = 1'b1;
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (op == ALU_MUL) begin
            check_val("mul_accept_rdy", {31'h0, in_ready}, 32'd0);
        end else begin
            check_val("simple_lat", {31'h0, out_valid}, 32'd1);
        end
    endtask

    logic [2:0]  ops [11] = '{ALU_ADD, 3'b110, ALU_SUB, ALU_SUB, ALU_SLT, ALU_SLT,
                              ALU_SLT, ALU_AND, ALU_OR, ALU_ADD, 3'b111};
    logic [31:0] as_ [11] = '{32'd5, 32'd5, 32'h80000000, 32'd9, 32'hFFFFFFFD, 32'd2,
                              32'h7FFFFFFF, 32'hF0F0A5A5, 32'h0F000001, 32'h7FFFFFFF, 32'd1};
    logic [31:0] bs_ [11] = '{32'd7, 32'd3, 32'd1, 32'd9, 32'd2, 32'hFFFFFFFD,
                              32'h80000000, 32'h0FF0FFFF, 32'h00F00010, 32'd1, 32'd2};

    initial begin
        // Reset state while rst is held
        #2;
        check_val("rst_ready", {31'h0, in_ready}, 32'd1);
        check_val("rst_valid", {31'h0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'h0);
        check_val("rst_flags", {30'h0, zero, overflow}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back simple ops with out_ready held high
        for (int i = 0; i < 11; i++) begin
            check_val("b2b_ready", {31'h0, in_ready}, 32'd1);
            issue(ops[i], as_[i], bs_[i]);
        end
        @(posedge clk);
        #1;

        // Multiply: fixed latency, operands ignored while busy
        issue(ALU_MUL, 32'hFFFFFFFF, 32'd3);
        for (int i = 0; i < 32; i++) begin
            check_val("mul_busy_rdy", {31'h0, in_ready}, 32'd0);
            check_val("mul_busy_valid", {31'h0, out_valid}, 32'd0);
            alu_control = ALU_ADD;
            src_a = $urandom;
            src_b = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_val("mul_done_valid", {31'h0, out_valid}, 32'd1);
        check_val("mul_result", result, 32'hFFFFFFFD);
        @(posedge clk);
        #1;

        // Backpressure then simultaneous drain and accept
        out_ready = 1'b0;
        issue(ALU_ADD, 32'h10, 32'h20);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_ready", {31'h0, in_ready}, 32'd0);
            check_val("bp_result", result, 32'h30);
            check_val("bp_valid", {31'h0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(ALU_SUB, 32'd100, 32'd1);
        check_val("bp_next", result, 32'd99);
        @(posedge clk);
        #1;

        // Reset during a multiply aborts it
        issue(ALU_MUL, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb_q.pop_back());
        #1;
        check_val("abort_valid", {31'h0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_ready", {31'h0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_no_result", {31'h0, out_valid}, 32'd0);
        issue(ALU_ADD, 32'd1, 32'd1);
        check_val("post_rst_add", result, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
